tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 142 ++++++++++++++
 tb/tb_tmds_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS 10b/8b channel decoder with token-based word alignment
module tmds_decoder #(
    parameter int LOCK_TOKENS      = 16,
    parameter int SEARCH_CYCLES    = 2048,
    parameter int SLIP_WAIT_CYCLES = 16,
    parameter int LOSS_CYCLES      = 4096
) (
    input  logic       i_pixclk,
    input  logic       i_rst_n,
    input  logic [9:0] i_encode,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_locked,
    output logic       o_bitslip
);

    localparam logic [1:0] ST_SEARCH    = 2'd0;
    localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
    localparam logic [1:0] ST_LOCKED    = 2'd2;

    localparam logic [12:0] LOCK_N      = 13'(LOCK_TOKENS);
    localparam logic [12:0] SEARCH_LAST = 13'(SEARCH_CYCLES - 1);
    localparam logic [12:0] SLIP_LAST   = 13'(SLIP_WAIT_CYCLES - 1);
    localparam logic [12:0] LOSS_LAST   = 13'(LOSS_CYCLES - 1);

    logic [9:0]  r_word;
    logic [1:0]  state, state_nxt;
    logic [12:0] tok_cnt, tok_nxt;
    logic [12:0] tmr, tmr_nxt;
    logic        slip_nxt;
    logic        is_tok;
    logic [1:0]  tok_val;
    logic [7:0]  d;
    logic [7:0]  dec;

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (r_word)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        d      = r_word[9] ? ~r_word[7:0] : r_word[7:0];
        dec    = 8'h00;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = r_word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        state_nxt = state;
        tok_nxt   = tok_cnt;
        tmr_nxt   = tmr;
        slip_nxt  = 1'b0;
        case (state)
            ST_SEARCH: begin
                tok_nxt = is_tok ? tok_cnt + 13'd1 : 13'd0;
                tmr_nxt = tmr + 13'd1;
                // A completed token run takes priority over the slip timeout
                if (is_tok && (tok_cnt + 13'd1 == LOCK_N)) begin
                    state_nxt = ST_LOCKED;
                    tok_nxt   = 13'd0;
                    tmr_nxt   = 13'd0;
                end else if (tmr == SEARCH_LAST) begin
                    state_nxt = ST_SLIP_WAIT;
                    slip_nxt  = 1'b1;
                    tok_nxt   = 13'd0;
                    tmr_nxt   = 13'd0;
                end
            end
            ST_SLIP_WAIT: begin
                tmr_nxt = tmr + 13'd1;
                if (tmr == SLIP_LAST) begin
                    state_nxt = ST_SEARCH;
                    tok_nxt   = 13'd0;
                    tmr_nxt   = 13'd0;
                end
            end
            ST_LOCKED: begin
                if (is_tok) begin
                    tmr_nxt = 13'd0;
                end else if (tmr == LOSS_LAST) begin
                    state_nxt = ST_SEARCH;
                    tok_nxt   = 13'd0;
                    tmr_nxt   = 13'd0;
                end else begin
                    tmr_nxt = tmr + 13'd1;
                end
            end
            default: begin
                state_nxt = ST_SEARCH;
                tok_nxt   = 13'd0;
                tmr_nxt   = 13'd0;
            end
        endcase
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_SEARCH;
            r_word    <= 10'd0;
            tok_cnt   <= 13'd0;
            tmr       <= 13'd0;
            o_data    <= 8'h00;
            o_ctrl    <= 2'b00;
            o_de      <= 1'b0;
            o_locked  <= 1'b0;
            o_bitslip <= 1'b0;
        end else begin
            r_word    <= i_encode;
            state     <= state_nxt;
            tok_cnt   <= tok_nxt;
            tmr       <= tmr_nxt;
            o_locked  <= (state_nxt == ST_LOCKED);
            o_bitslip <= slip_nxt;
            // Output gating follows the state held before this edge
            if (state == ST_LOCKED) begin
                if (is_tok) begin
                    o_de   <= 1'b0;
                    o_data <= 8'h00;
                    o_ctrl <= tok_val;
                end else begin
                    o_de   <= 1'b1;
                    o_data <= dec;
                end
            end else begin
                o_de   <= 1'b0;
                o_data <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - self-checking bench for tmds_decoder against a reference model
module tb_tmds_decoder;

    localparam int LOCK_N  = 16;
    localparam int SEARCH  = 2048;
    localparam int SWAIT   = 16;
    localparam int LOSS    = 4096;

    localparam int M_HUNT  = 0;
    localparam int M_PAUSE = 1;
    localparam int M_SYNC  = 2;

    localparam logic [9:0] DW = 10'b0000011111;

    logic       i_pixclk;
    logic       i_rst_n;
    logic [9:0] i_encode;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de;
    logic       o_locked;
    logic       o_bitslip;

    tmds_decoder dut (
        .i_pixclk (i_pixclk),
        .i_rst_n  (i_rst_n),
        .i_encode (i_encode),
        .o_data   (o_data),
        .o_ctrl   (o_ctrl),
        .o_de     (o_de),
        .o_locked (o_locked),
        .o_bitslip(o_bitslip)
    );

    initial begin
        i_pixclk = 1'b0;
        forever #5 i_pixclk = ~i_pixclk;
    end

    int checks;
    int errors;
    int step_no;
    int slips[$];

    logic [9:0] tokens [4];
    int         m_mode;
    int         m_run;
    int         m_age;
    logic [9:0] m_prev;
    logic [7:0] exp_data;
    logic [1:0] exp_ctrl;
    logic       exp_de;
    logic       exp_locked;
    logic       exp_slip;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp_v, step_no);
        end
    endtask

    function automatic int tok_idx(input logic [9:0] w);
        for (int k = 0; k < 4; k++) begin
            if (tokens[k] == w) return k;
        end
        return -1;
    endfunction

    // Find the byte whose TMDS encoding (with the word's own mode bits) yields w
    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] dd;
        logic [7:0] q;
        for (int b = 0; b < 256; b++) begin
            dd   = 8'(b);
            q[0] = dd[0];
            for (int i = 1; i < 8; i++) begin
                q[i] = w[8] ? (q[i-1] ^ dd[i]) : ~(q[i-1] ^ dd[i]);
            end
            if ((w[9] ? ~q : q) == w[7:0]) return dd;
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_mode = M_HUNT; m_run = 0; m_age = 0; m_prev = 10'd0;
        exp_data = 8'h00; exp_ctrl = 2'b00; exp_de = 1'b0;
        exp_locked = 1'b0; exp_slip = 1'b0;
    endtask

    task automatic model_edge(input logic [9:0] w);
        int t;
        t = tok_idx(m_prev);
        exp_slip = 1'b0;
        if (m_mode == M_SYNC) begin
            if (t >= 0) begin
                exp_de = 1'b0; exp_data = 8'h00; exp_ctrl = 2'(t);
            end else begin
                exp_de = 1'b1; exp_data = ref_decode(m_prev);
            end
        end else begin
            exp_de = 1'b0; exp_data = 8'h00;
        end
        case (m_mode)
            M_HUNT: begin
                m_run = (t >= 0) ? m_run + 1 : 0;
                m_age++;
                if (m_run == LOCK_N) begin
                    m_mode = M_SYNC; m_run = 0; m_age = 0;
                end else if (m_age == SEARCH) begin
                    m_mode = M_PAUSE; m_run = 0; m_age = 0; exp_slip = 1'b1;
                end
            end
            M_PAUSE: begin
                m_age++;
                if (m_age == SWAIT) begin
                    m_mode = M_HUNT; m_run = 0; m_age = 0;
                end
            end
            default: begin
                m_age = (t >= 0) ? 0 : m_age + 1;
                if (m_age == LOSS) begin
                    m_mode = M_HUNT; m_run = 0; m_age = 0;
                end
            end
        endcase
        exp_locked = (m_mode == M_SYNC);
        m_prev = w;
    endtask

    task automatic step(input logic [9:0] w);
        i_encode = w;
        @(posedge i_pixclk);
        model_edge(w);
        @(negedge i_pixclk);
        step_no++;
        if (o_bitslip) slips.push_back(step_no);
        check("data",    16'(o_data),    16'(exp_data));
        check("ctrl",    16'(o_ctrl),    16'(exp_ctrl));
        check("de",      16'(o_de),      16'(exp_de));
        check("locked",  16'(o_locked),  16'(exp_locked));
        check("bitslip", 16'(o_bitslip), 16'(exp_slip));
    endtask

    // Assert reset between edges, confirm outputs clear at once, release at a falling edge
    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_data",    16'(o_data),    16'h0);
        check("rst_ctrl",    16'(o_ctrl),    16'h0);
        check("rst_de",      16'(o_de),      16'h0);
        check("rst_locked",  16'(o_locked),  16'h0);
        check("rst_bitslip", 16'(o_bitslip), 16'h0);
        @(negedge i_pixclk);
        @(negedge i_pixclk);
        i_rst_n = 1'b1;
        model_reset();
        step_no = 0;
        slips.delete();
    endtask

    initial begin
        int first_slip;
        int second_slip;
        tokens[0] = 10'b1101010100;
        tokens[1] = 10'b0010101011;
        tokens[2] = 10'b0101010100;
        tokens[3] = 10'b1010101011;
        checks = 0; errors = 0; step_no = 0;
        i_rst_n = 1'b0;
        i_encode = 10'd0;
        model_reset();
        @(negedge i_pixclk);
        do_reset();

        // Basic lock on the first token run
        repeat (16) step(tokens[0]);
        check("lock_early", 16'(o_locked), 16'h0);
        step(tokens[0]);
        check("lock_edge", 16'(o_locked), 16'h1);
        step(tokens[0]);
        check("tok_de", 16'(o_de), 16'h0);
        check("tok_ctrl", 16'(o_ctrl), 16'h0);

        // Directed data decode, two cycles of latency
        step(10'b0100000000);
        step(10'b0111111111);
        check("dec_00", 16'(o_data), 16'h00);
        check("dec_00_de", 16'(o_de), 16'h1);
        step(10'b1011111111);
        check("dec_01", 16'(o_data), 16'h01);
        step(tokens[3]);
        check("dec_fe", 16'(o_data), 16'hFE);
        step(tokens[0]);
        check("ctrl_11", 16'(o_ctrl), 16'h3);
        check("ctrl_11_de", 16'(o_de), 16'h0);

        // Reset while locked, then lock again from scratch
        do_reset();
        repeat (16) step(tokens[0]);
        check("relock_early", 16'(o_locked), 16'h0);
        step(tokens[0]);
        check("relock_edge", 16'(o_locked), 16'h1);

        // Interrupted token run
        do_reset();
        repeat (15) step(tokens[0]);
        step(DW);
        repeat (16) step(tokens[0]);
        check("intr_early", 16'(o_locked), 16'h0);
        step(tokens[0]);
        check("intr_lock", 16'(o_locked), 16'h1);

        // Lock completes on the same cycle the search timer expires
        do_reset();
        repeat (SEARCH - 17) step(DW);
        repeat (17) step(tokens[1]);
        check("tie_lock", 16'(o_locked), 16'h1);
        check("tie_slip", 16'(o_bitslip), 16'h0);

        // Loss of lock after a long data run, then relock
        repeat (LOSS) step(DW);
        check("loss_early", 16'(o_locked), 16'h1);
        step(DW);
        check("loss_drop", 16'(o_locked), 16'h0);
        check("loss_slips", 16'(slips.size()), 16'h0);
        repeat (16) step(tokens[2]);
        check("loss_relock_early", 16'(o_locked), 16'h0);
        step(tokens[2]);
        check("loss_relock", 16'(o_locked), 16'h1);

        // Randomized traffic while locked
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) step(tokens[$urandom_range(0, 3)]);
            else                           step(10'($urandom));
        end

        // No-lock stream: periodic bit-slip requests
        do_reset();
        repeat (4200) step(DW);
        check("slip_count", 16'(slips.size()), 16'h2);
        first_slip  = (slips.size() > 0) ? slips[0] : -1;
        second_slip = (slips.size() > 1) ? slips[1] : -1;
        check("slip_first", 16'(first_slip), 16'(SEARCH));
        check("slip_second", 16'(second_slip), 16'(2 * SEARCH + SWAIT));

        // Randomized stream while searching
        do_reset();
        repeat (2500) step(10'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
